ldpc_ber_monitor: RTL

Synthesizable error-rate monitor for hardware-in-the-loop LDPC decoder measurement. It buffers transmitted reference words and compares decoded words against them. It accumulates bit, frame and undetected-error counts over a programmable frame window. It sits beside ldpc_decoder_top, fed by the channel stimulus source and the decoder output, and replaces software BER/FER tallying for long runs.

---
 rtl/ldpc_ber_pkg.sv | 26 ++
 rtl/ldpc_ber_popcount.sv | 34 +++
 rtl/ldpc_ber_monitor.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_ber_pkg.sv
// ldpc_ber_pkg: shared types and helpers for the LDPC BER monitor.
//   state_e   : measurement FSM states
//   pc_width  : bits needed to hold a popcount of 'lanes' bits
//   sat_add   : add two values and clamp at the all-ones value of width w (w <= 64)
package ldpc_ber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int pc_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int w);
        logic [64:0] s;
        logic [63:0] mx;
        mx = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        s  = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, mx}) ? mx : s[63:0];
    endfunction

endpackage

// File: rtl/ldpc_ber_popcount.sv
// ldpc_ber_popcount: registered population count, 1 cycle latency.
//   clk, rst : clock, synchronous active-high reset
//   in_bits  : LANES-bit word to count
//   count    : number of ones in in_bits from the previous cycle
module ldpc_ber_popcount
    import ldpc_ber_pkg::*;
#(
    parameter int LANES = 56,
    parameter int PC_W  = pc_width(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] in_bits,
    output logic [PC_W-1:0]  count
);

    logic [PC_W-1:0] count_d, count_q;

    // Plain bit sum; synthesis balances it into an adder tree.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < LANES; i++) begin
            count_d = count_d + PC_W'(in_bits[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/ldpc_ber_monitor.sv
// ldpc_ber_monitor: bit/frame error-rate monitor for LDPC decoder measurement.
// Buffers reference words in a small FIFO, compares each decoded word with the
// FIFO head and accumulates saturating error statistics over a frame window.
//   cfg_frames            : frames per measurement (0 = until abort)
//   meas_start/meas_abort : start (clear + RUN) / abort (flush + IDLE) pulses
//   ref_valid/ref_ready/ref_bits : reference word input
//   dec_valid/dec_bits/dec_success/dec_iters : decoder result input
//   busy, done            : FSM in RUN / DONE
//   frames_seen, bit_errors, frame_errors, undet_errors, sync_err : statistics
//   iter_sum, iter_max    : iteration stats, built only when
//                           LDPC_BER_MON_ITER_STATS_EN is defined, else 0
// Pipeline: dec cycle XOR -> reg, popcount -> reg, counter update; counters
// reflect a frame two cycles after its dec_valid is sampled.
module ldpc_ber_monitor
    import ldpc_ber_pkg::*;
#(
    parameter int LANES     = 56,
    parameter int REF_DEPTH = 4,
    parameter int CNT_W     = 32,
    parameter int FRM_W     = 24,
    parameter int ITER_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FRM_W-1:0]  cfg_frames,
    input  logic              meas_start,
    input  logic              meas_abort,
    input  logic              ref_valid,
    output logic              ref_ready,
    input  logic [LANES-1:0]  ref_bits,
    input  logic              dec_valid,
    input  logic [LANES-1:0]  dec_bits,
    input  logic              dec_success,
    input  logic [ITER_W-1:0] dec_iters,
    output logic              busy,
    output logic              done,
    output logic [FRM_W-1:0]  frames_seen,
    output logic [CNT_W-1:0]  bit_errors,
    output logic [FRM_W-1:0]  frame_errors,
    output logic [FRM_W-1:0]  undet_errors,
    output logic              sync_err,
    output logic [CNT_W-1:0]  iter_sum,
    output logic [ITER_W-1:0] iter_max
);

    localparam int PC_W  = pc_width(LANES);
    localparam int PTR_W = $clog2(REF_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    state_e state_q, state_d;

    logic [LANES-1:0] mem_q [REF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic go, full, empty, ref_rdy, push, pop, dec_acc, upd, f_err, u_err;

    logic             s1_vld_q, s1_vld_d, s1_sync_q, s1_sync_d, s1_succ_q, s1_succ_d;
    logic [LANES-1:0] s1_xor_q, s1_xor_d;
    logic             s2_vld_q, s2_vld_d, s2_sync_q, s2_sync_d, s2_succ_q, s2_succ_d;
    logic [PC_W-1:0]  pc;

    logic [FRM_W-1:0] frames_q, frames_d, ferr_q, ferr_d, uerr_q, uerr_d;
    logic [CNT_W-1:0] bits_q, bits_d;
    logic             sync_q, sync_d;

    // Control and reference FIFO. Full uses the registered occupancy, so a
    // push is refused while full even if a pop happens in the same cycle.
    always_comb begin
        go      = meas_start && !meas_abort && (state_q != ST_RUN);
        full    = (occ_q == OCC_W'(REF_DEPTH));
        empty   = (occ_q == '0);
        ref_rdy = (state_q == ST_RUN) && !full;
        push    = ref_valid && ref_rdy && !meas_abort;
        dec_acc = dec_valid && (state_q == ST_RUN) && !meas_abort;
        pop     = dec_acc && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (go || meas_abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Stages 1 and 2. An empty FIFO yields a zero XOR so the frame adds no
    // bit errors but is still flagged through the sync bit.
    always_comb begin
        s1_vld_d  = dec_acc;
        s1_xor_d  = empty ? '0 : (dec_bits ^ mem_q[rd_ptr_q]);
        s1_sync_d = empty;
        s1_succ_d = dec_success;
        s2_vld_d  = s1_vld_q && !meas_abort;
        s2_sync_d = s1_sync_q;
        s2_succ_d = s1_succ_q;
    end

    ldpc_ber_popcount #(.LANES(LANES), .PC_W(PC_W)) u_popcount (
        .clk     (clk),
        .rst     (rst),
        .in_bits (s1_xor_q),
        .count   (pc)
    );

    // Stage 3: counters and FSM. Frames still in flight when the window
    // closes (state no longer RUN) are dropped.
    always_comb begin
        upd    = s2_vld_q && (state_q == ST_RUN) && !meas_abort;
        f_err  = (pc != '0) || !s2_succ_q || s2_sync_q;
        u_err  = (pc != '0) && s2_succ_q;
        frames_d = frames_q;
        bits_d   = bits_q;
        ferr_d   = ferr_q;
        uerr_d   = uerr_q;
        sync_d   = sync_q;
        state_d  = state_q;
        if (go) begin
            frames_d = '0;
            bits_d   = '0;
            ferr_d   = '0;
            uerr_d   = '0;
            sync_d   = 1'b0;
        end else if (upd) begin
            frames_d = FRM_W'(sat_add(64'(frames_q), 64'd1, FRM_W));
            bits_d   = CNT_W'(sat_add(64'(bits_q), 64'(pc), CNT_W));
            if (f_err) ferr_d = FRM_W'(sat_add(64'(ferr_q), 64'd1, FRM_W));
            if (u_err) uerr_d = FRM_W'(sat_add(64'(uerr_q), 64'd1, FRM_W));
            if (s2_sync_q) sync_d = 1'b1;
        end
        if (meas_abort)
            state_d = ST_IDLE;
        else if (go)
            state_d = ST_RUN;
        else if (upd && (cfg_frames != '0) && (frames_d == cfg_frames))
            state_d = ST_DONE;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ref_bits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_xor_q  <= '0;
            s1_sync_q <= 1'b0;
            s1_succ_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_sync_q <= 1'b0;
            s2_succ_q <= 1'b0;
            frames_q  <= '0;
            bits_q    <= '0;
            ferr_q    <= '0;
            uerr_q    <= '0;
            sync_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            s1_vld_q  <= s1_vld_d;
            s1_xor_q  <= s1_xor_d;
            s1_sync_q <= s1_sync_d;
            s1_succ_q <= s1_succ_d;
            s2_vld_q  <= s2_vld_d;
            s2_sync_q <= s2_sync_d;
            s2_succ_q <= s2_succ_d;
            frames_q  <= frames_d;
            bits_q    <= bits_d;
            ferr_q    <= ferr_d;
            uerr_q    <= uerr_d;
            sync_q    <= sync_d;
        end
    end

`ifdef LDPC_BER_MON_ITER_STATS_EN
    logic [ITER_W-1:0] s1_iters_q, s2_iters_q, imax_q, imax_d;
    logic [CNT_W-1:0]  isum_q, isum_d;

    always_comb begin
        isum_d = isum_q;
        imax_d = imax_q;
        if (go) begin
            isum_d = '0;
            imax_d = '0;
        end else if (upd) begin
            isum_d = CNT_W'(sat_add(64'(isum_q), 64'(s2_iters_q), CNT_W));
            if (s2_iters_q > imax_q) imax_d = s2_iters_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_iters_q <= '0;
            s2_iters_q <= '0;
            isum_q     <= '0;
            imax_q     <= '0;
        end else begin
            s1_iters_q <= dec_iters;
            s2_iters_q <= s1_iters_q;
            isum_q     <= isum_d;
            imax_q     <= imax_d;
        end
    end

    assign iter_sum = isum_q;
    assign iter_max = imax_q;
`else
    logic unused_iters;
    assign unused_iters = ^dec_iters;
    assign iter_sum     = '0;
    assign iter_max     = '0;
`endif

    assign ref_ready    = ref_rdy;
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign frames_seen  = frames_q;
    assign bit_errors   = bits_q;
    assign frame_errors = ferr_q;
    assign undet_errors = uerr_q;
    assign sync_err     = sync_q;

endmodule
